// File: rtl/time_keeper_if.sv
// Control and time-display bundle for time_keeper: the bench drives the
// controls through master, and the clock core sits on slave.
interface time_keeper_if;
  logic       run;
  logic       set_time;
  logic [5:0] key_hour;
  logic [5:0] key_minute;
  logic       inc_h;
  logic       inc_m;
  logic       mode12;
  logic [5:0] hour;
  logic [5:0] minute;
  logic [5:0] second;
  logic [5:0] disp_hour;
  logic       pm;
  logic       sec_tick;
  logic       day_tick;
  logic       load_err;

  modport master (
    output run, set_time, key_hour, key_minute, inc_h, inc_m, mode12,
    input  hour, minute, second, disp_hour, pm, sec_tick, day_tick, load_err
  );

  modport slave (
    input  run, set_time, key_hour, key_minute, inc_h, inc_m, mode12,
    output hour, minute, second, disp_hour, pm, sec_tick, day_tick, load_err
  );
endinterface

// File: rtl/time_keeper.sv
// 24-hour clock. It has a seconds prescaler, a key load, auto-repeat
// hour/minute adjust and a 12-hour display mapping.
module time_keeper #(
  parameter int TICK_DIV      = 100000000,
  parameter int STEP_DIV      = 5000000,
  parameter int TICKS_PER_SEC = 1
) (
  input logic          clk,
  input logic          rst_n,
  time_keeper_if.slave bus
);
  localparam int PW = $clog2(TICK_DIV);
  localparam int RW = $clog2(STEP_DIV);

  logic [PW-1:0] presc, presc_nx;
  logic [RW-1:0] rep_h, rep_m;
  logic          inc_h_d, inc_m_d;
  logic [5:0]    hour, minute, second;
  logic [5:0]    hour_nx, minute_nx, second_nx, disp_nx;
  logic          sec_tick_nx, day_tick_nx, load_err_nx;
  logic          tick, step_h, step_m, load_ok, carry_s, carry_m;
  logic [6:0]    sec_sum;

  always_comb begin
    tick    = bus.run && (presc == PW'(TICK_DIV - 1));
    load_ok = (bus.key_hour <= 6'd23) && (bus.key_minute <= 6'd59);
    // A step fires on the rising edge and then once every STEP_DIV cycles after it.
    step_h  = bus.inc_h && (!inc_h_d || rep_h == RW'(STEP_DIV - 1));
    step_m  = bus.inc_m && (!inc_m_d || rep_m == RW'(STEP_DIV - 1));

    presc_nx    = presc;
    hour_nx     = hour;
    minute_nx   = minute;
    second_nx   = second;
    sec_tick_nx = 1'b0;
    day_tick_nx = 1'b0;
    load_err_nx = 1'b0;
    carry_s     = 1'b0;
    carry_m     = 1'b0;
    sec_sum     = 7'(second) + 7'(TICKS_PER_SEC);

    if (bus.set_time) begin
      if (load_ok) begin
        hour_nx   = bus.key_hour;
        minute_nx = bus.key_minute;
        second_nx = '0;
        presc_nx  = '0;
      end else begin
        load_err_nx = 1'b1;
      end
    end else begin
      if (bus.run)
        presc_nx = tick ? '0 : presc + PW'(1);
      if (tick) begin
        sec_tick_nx = 1'b1;
        if (sec_sum >= 7'd60) begin
          second_nx = 6'(sec_sum - 7'd60);
          carry_s   = 1'b1;
        end else begin
          second_nx = 6'(sec_sum);
        end
      end
      // If a field takes an adjust step, any carry into that same field is
      // dropped, so the field changes by exactly one.
      if (step_m)
        minute_nx = (minute == 6'd59) ? '0 : minute + 6'd1;
      else if (carry_s) begin
        carry_m   = (minute == 6'd59);
        minute_nx = carry_m ? '0 : minute + 6'd1;
      end
      if (step_h)
        hour_nx = (hour == 6'd23) ? '0 : hour + 6'd1;
      else if (carry_m) begin
        day_tick_nx = (hour == 6'd23);
        hour_nx     = day_tick_nx ? '0 : hour + 6'd1;
      end
    end

    if (!bus.mode12)          disp_nx = hour_nx;
    else if (hour_nx == 6'd0) disp_nx = 6'd12;
    else if (hour_nx > 6'd12) disp_nx = hour_nx - 6'd12;
    else                      disp_nx = hour_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc         <= '0;
      rep_h         <= '0;
      rep_m         <= '0;
      inc_h_d       <= 1'b0;
      inc_m_d       <= 1'b0;
      hour          <= '0;
      minute        <= '0;
      second        <= '0;
      bus.disp_hour <= bus.mode12 ? 6'd12 : 6'd0;
      bus.pm        <= 1'b0;
      bus.sec_tick  <= 1'b0;
      bus.day_tick  <= 1'b0;
      bus.load_err  <= 1'b0;
    end else begin
      presc         <= presc_nx;
      inc_h_d       <= bus.inc_h;
      inc_m_d       <= bus.inc_m;
      rep_h         <= (!bus.inc_h || step_h) ? '0 : rep_h + RW'(1);
      rep_m         <= (!bus.inc_m || step_m) ? '0 : rep_m + RW'(1);
      hour          <= hour_nx;
      minute        <= minute_nx;
      second        <= second_nx;
      bus.disp_hour <= disp_nx;
      bus.pm        <= (hour_nx >= 6'd12);
      bus.sec_tick  <= sec_tick_nx;
      bus.day_tick  <= day_tick_nx;
      bus.load_err  <= load_err_nx;
    end
  end

  assign bus.hour   = hour;
  assign bus.minute = minute;
  assign bus.second = second;
endmodule

// File: tb/tb_time_keeper.sv
// Directed bench for time_keeper with TICK_DIV=4, STEP_DIV=3 and
// TICKS_PER_SEC=1; every expected value is hand-computed.
module tb_time_keeper;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  time_keeper_if tk();

  time_keeper #(.TICK_DIV(4), .STEP_DIV(3), .TICKS_PER_SEC(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (tk.slave)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic load(input int h, input int m);
    tk.key_hour   = 6'(h);
    tk.key_minute = 6'(m);
    tk.set_time   = 1'b1;
    cyc(1);
    tk.set_time   = 1'b0;
  endtask

  initial begin
    int last, ticks, days, sec_hold;
    rst_n = 1'b0;
    tk.run = 1'b0; tk.set_time = 1'b0; tk.key_hour = '0; tk.key_minute = '0;
    tk.inc_h = 1'b0; tk.inc_m = 1'b0; tk.mode12 = 1'b0;
    cyc(2);
    chk("rst_hour", tk.hour, 0);
    chk("rst_minute", tk.minute, 0);
    chk("rst_second", tk.second, 0);
    chk("rst_disp", tk.disp_hour, 0);
    chk("rst_pm", tk.pm, 0);
    chk("rst_sec_tick", tk.sec_tick, 0);

    // One minute of ticks: 60 pulses, 4 cycles apart.
    rst_n = 1'b1; tk.run = 1'b1;
    last = -1; ticks = 0;
    for (int i = 1; i <= 240; i++) begin
      cyc(1);
      if (tk.sec_tick) begin
        if (last < 0) chk("first_tick", i, 4);
        else          chk("tick_gap", i - last, 4);
        last = i; ticks++;
      end
    end
    chk("tick_count", ticks, 60);
    chk("min1_second", tk.second, 0);
    chk("min1_minute", tk.minute, 1);
    chk("min1_hour", tk.hour, 0);

    // Day wrap from 23:59:00.
    load(23, 59);
    chk("ld_hour", tk.hour, 23);
    chk("ld_minute", tk.minute, 59);
    chk("ld_second", tk.second, 0);
    days = 0;
    for (int i = 1; i <= 240; i++) begin
      cyc(1);
      if (tk.day_tick) days++;
      if (i == 240) begin
        chk("wrap_day_tick", tk.day_tick, 1);
        chk("wrap_hour", tk.hour, 0);
        chk("wrap_minute", tk.minute, 0);
        chk("wrap_second", tk.second, 0);
      end
    end
    chk("day_tick_count", days, 1);
    cyc(1);
    chk("day_tick_clear", tk.day_tick, 0);

    // Rejected load, then 12-hour display.
    tk.run = 1'b0; tk.mode12 = 1'b1;
    load(24, 10);
    chk("err_pulse", tk.load_err, 1);
    chk("err_hour", tk.hour, 0);
    chk("err_minute", tk.minute, 0);
    cyc(1);
    chk("err_clear", tk.load_err, 0);
    load(12, 0);
    chk("noon_disp", tk.disp_hour, 12);
    chk("noon_pm", tk.pm, 1);
    load(15, 7);
    chk("pm3_disp", tk.disp_hour, 3);
    chk("pm3_pm", tk.pm, 1);
    load(0, 0);
    chk("midnight_disp", tk.disp_hour, 12);
    chk("midnight_pm", tk.pm, 0);

    // Auto-repeat minute adjust from 09:58.
    load(9, 58);
    tk.inc_m = 1'b1;
    cyc(1); chk("rep_c1", tk.minute, 59);
    cyc(2); chk("rep_c3", tk.minute, 59);
    cyc(1); chk("rep_c4", tk.minute, 0);
    cyc(3); chk("rep_c7", tk.minute, 1);
    chk("rep_hour", tk.hour, 9);
    tk.inc_m = 1'b0;
    cyc(1);

    // Adjust step coincident with a tick from 10:59:59.
    tk.run = 1'b1;
    load(10, 59);
    cyc(239);
    chk("pre_second", tk.second, 59);
    chk("pre_minute", tk.minute, 59);
    tk.inc_m = 1'b1;
    cyc(1);
    chk("co_hour", tk.hour, 10);
    chk("co_minute", tk.minute, 0);
    chk("co_second", tk.second, 0);
    chk("co_sec_tick", tk.sec_tick, 1);
    chk("co_day_tick", tk.day_tick, 0);
    tk.inc_m = 1'b0;
    cyc(2);

    // Freeze, load while frozen, reset in the middle of an hour hold.
    tk.run = 1'b0;
    sec_hold = int'(tk.second);
    cyc(20);
    chk("frozen_second", tk.second, sec_hold);
    chk("frozen_tick", tk.sec_tick, 0);
    load(8, 30);
    chk("ld830_hour", tk.hour, 8);
    chk("ld830_minute", tk.minute, 30);
    chk("ld830_second", tk.second, 0);
    chk("ld830_disp", tk.disp_hour, 8);
    tk.inc_h = 1'b1;
    cyc(1); chk("h_step", tk.hour, 9);
    cyc(1);
    rst_n = 1'b0;
    cyc(1);
    chk("mid_rst_hour", tk.hour, 0);
    chk("mid_rst_minute", tk.minute, 0);
    chk("mid_rst_disp", tk.disp_hour, 12);
    chk("mid_rst_pm", tk.pm, 0);
    rst_n = 1'b1;
    cyc(1); chk("rel_step", tk.hour, 1);
    chk("rel_disp", tk.disp_hour, 1);
    cyc(2); chk("rel_hold", tk.hour, 1);
    cyc(1); chk("rel_repeat", tk.hour, 2);
    tk.inc_h = 1'b0;
    cyc(1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
